mem_store_buffer: RTL and testbench
===================================

// Module: mem_store_buffer
// PURPOSE
// MEM-stage store buffer between the EX/MEM pipeline register and the data memory.
// Stores are queued in a small FIFO and retire to memory only in cycles when the port is idle.
// Loads read memory combinationally. The youngest matching queued store forwards its data to a load.
// Load results are registered into MEM/WB. A stall is raised on a full buffer or during a flush.
// PARAMETERS
// DATA_WIDTH     32  data word width
// ADDRESS_WIDTH  32  word-index address width, same as the data memory addr port
// SB_DEPTH        4  store-buffer entries; power of two, >=2
// PORTS
// clk             in   1              rising-edge clock
// reset           in   1              synchronous, active-low
// exValid         in   1              EX/MEM op valid this cycle
// exMemRead       in   1              op is a load
// exMemWrite      in   1              op is a store; exMemRead & exMemWrite never both 1
// exAddr          in   ADDRESS_WIDTH  word address
// exStoreData     in   DATA_WIDTH     store data
// flush           in   1              level request: drain the buffer fully before any further op
// stall           out  1              op not accepted this cycle; upstream holds its inputs
// dmemAddr        out  ADDRESS_WIDTH  to data memory addr
// dmemWriteData   out  DATA_WIDTH     to data memory writeData
// dmemWriteEnable out  1              to data memory writeEnable
// dmemReadData    in   DATA_WIDTH     from data memory readData (asynchronous)
// wbLoadData      out  DATA_WIDTH     registered load result (MEM/WB)
// wbLoadValid     out  1              registered: wbLoadData is valid
// sbCount         out  $clog2(SB_DEPTH)+1  current occupancy
// sbEmpty         out  1              sbCount==0
// BEHAVIOUR
// - Reset (reset==0 at posedge): wbLoadData=0, wbLoadValid=0, pointers and count=0; queued stores are discarded, not written.
// - Derived: ld = exValid&exMemRead; st = exValid&exMemWrite; full = (sbCount==SB_DEPTH).
// - stall = (flush & !sbEmpty) | (st & full). Combinational. A stalled op has no effect.
// - portBusy = !stall & (ld|st). drain = !portBusy & !sbEmpty.
// - Drain writes the oldest entry: dmemWriteEnable=1, dmemAddr/dmemWriteData = head entry; pop at posedge.
// - No drain: dmemWriteEnable=0 and dmemAddr=exAddr (load path). The write data value is don't-care.
// - Store accepted (st & !stall): push {exAddr,exStoreData} at tail. Memory is not touched that cycle.
// - Push and pop never occur in the same cycle, because portBusy excludes drain.
// - Load accepted (ld & !stall): scan all valid entries for addr==exAddr.
//   - On a hit, use the data of the youngest matching entry.
//   - On a miss, use dmemReadData.
//   - The result is latched into wbLoadData at posedge with wbLoadValid=1.
//   - In any other cycle, wbLoadValid<=0 and wbLoadData holds its value.
// - Single-cycle load latency: EX/MEM cycle N -> wbLoadValid in cycle N+1.
// - Full plus incoming store: stall=1. The port is idle, so one entry drains that cycle and the store is accepted next cycle.
// - Flush while empty: stall=0 and ops proceed normally. Flush with entries: stall until empty, draining one entry per cycle.
// - Pointers wrap modulo SB_DEPTH. The count distinguishes full from empty.
// - Memory order: entries retire strictly FIFO, so repeated stores to one address retire in program order.
// STRUCTURE
// - Package mem_stage_pkg holds:
//   - SB_DEPTH_DEFAULT and the entry struct/type {addr,data}.
//   - Helper function for the pointer width.
// - One sub-module, sb_fifo: storage, head/tail/count, push/pop, plus a per-entry valid vector exported for the forwarding scan.
// - Top level holds: the stall/drain arbitration, the youngest-match priority scan (tail-1 down to head), and the MEM/WB register.
// TESTING
// - Reset with 3 entries queued -> sbCount=0, wbLoadValid=0, no dmemWriteEnable pulse afterwards; memory unchanged.
// - Stores A=5/0x11, 6/0x22 back-to-back, then idle -> sbCount 1,2.
//   - The following two idle cycles write (5,0x11) then (6,0x22), each with dmemWriteEnable=1.
// - Stores 7/0xAA then 7/0xBB, then load 7 -> next cycle wbLoadData=0xBB (youngest forward); memory still holds the old value.
// - Load from address 9 with no match and memory[9]=0x1234 -> wbLoadData=0x1234 and wbLoadValid=1 exactly one cycle later.
// - Fill 4 stores, then a 5th store -> stall=1 for one cycle with a drain that cycle; the 5th store is accepted next cycle, sbCount=4.
// - flush=1 with 3 entries -> stall=1 for 3 cycles with 3 FIFO-order writes, then stall=0 and sbEmpty=1.

Source files
------------

// File: rtl/mem_store_buffer_pkg.sv
// Shared types and helpers for the MEM-stage store buffer.
// Holds the default depth, the queued-store entry type and the pointer-width helper.
package mem_stage_pkg;

  localparam int SB_DEPTH_DEFAULT      = 4;
  localparam int DATA_WIDTH_DEFAULT    = 32;
  localparam int ADDRESS_WIDTH_DEFAULT = 32;

  typedef struct packed {
    logic [ADDRESS_WIDTH_DEFAULT-1:0] addr;
    logic [DATA_WIDTH_DEFAULT-1:0]    data;
  } sb_entry_t;

  // Pointer width for a power-of-two depth; never narrower than one bit.
  function automatic int sb_ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_store_buffer_sb_fifo.sv
// Store-buffer FIFO: entry storage, head/tail/count bookkeeping and a per-entry
// valid vector exported so the top level can scan live entries for forwarding.
module sb_fifo
  import mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEFAULT,
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEFAULT,
  parameter int SB_DEPTH      = SB_DEPTH_DEFAULT,
  localparam int PW           = sb_ptr_width(SB_DEPTH),
  localparam int CW           = $clog2(SB_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [ADDRESS_WIDTH-1:0] push_addr,
  input  logic [DATA_WIDTH-1:0]    push_data,
  input  logic                     pop,
  output logic [ADDRESS_WIDTH-1:0] head_addr,
  output logic [DATA_WIDTH-1:0]    head_data,
  output logic [CW-1:0]            count,
  output logic [PW-1:0]            tail_ptr,
  output logic [SB_DEPTH-1:0]      entry_valid,
  output logic [ADDRESS_WIDTH-1:0] entry_addr [SB_DEPTH],
  output logic [DATA_WIDTH-1:0]    entry_data [SB_DEPTH]
);

  logic [ADDRESS_WIDTH-1:0] addr_r  [SB_DEPTH];
  logic [DATA_WIDTH-1:0]    data_r  [SB_DEPTH];
  logic [PW-1:0]            head_r;
  logic [PW-1:0]            tail_r;
  logic [CW-1:0]            count_r;
  logic [SB_DEPTH-1:0]      valid_r;

  // Entry payload storage; contents are meaningless unless the valid bit is set.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_r[tail_r] <= push_addr;
      data_r[tail_r] <= push_data;
    end
  end

  // Pointer, occupancy and valid-vector bookkeeping; pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
      valid_r <= '0;
    end else if (push) begin
      tail_r          <= tail_r + PW'(1);
      count_r         <= count_r + CW'(1);
      valid_r[tail_r] <= 1'b1;
    end else if (pop) begin
      head_r          <= head_r + PW'(1);
      count_r         <= count_r - CW'(1);
      valid_r[head_r] <= 1'b0;
    end
  end

  assign head_addr   = addr_r[head_r];
  assign head_data   = data_r[head_r];
  assign count       = count_r;
  assign tail_ptr    = tail_r;
  assign entry_valid = valid_r;
  assign entry_addr  = addr_r;
  assign entry_data  = data_r;

endmodule

// File: rtl/mem_store_buffer.sv
// MEM-stage store buffer: stores queue and retire on idle port cycles, loads read
// memory combinationally with youngest-store forwarding, results registered to MEM/WB.
module mem_store_buffer
  import mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int SB_DEPTH      = SB_DEPTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      exValid,
  input  logic                      exMemRead,
  input  logic                      exMemWrite,
  input  logic [ADDRESS_WIDTH-1:0]  exAddr,
  input  logic [DATA_WIDTH-1:0]     exStoreData,
  input  logic                      flush,
  output logic                      stall,
  output logic [ADDRESS_WIDTH-1:0]  dmemAddr,
  output logic [DATA_WIDTH-1:0]     dmemWriteData,
  output logic                      dmemWriteEnable,
  input  logic [DATA_WIDTH-1:0]     dmemReadData,
  output logic [DATA_WIDTH-1:0]     wbLoadData,
  output logic                      wbLoadValid,
  output logic [$clog2(SB_DEPTH):0] sbCount,
  output logic                      sbEmpty
);

  localparam int PW = sb_ptr_width(SB_DEPTH);
  localparam int CW = $clog2(SB_DEPTH) + 1;

  logic                     ld_s, st_s, full_s, empty_s, stall_s;
  logic                     port_busy_s, drain_s, accept_ld_s, accept_st_s;
  logic [ADDRESS_WIDTH-1:0] head_addr_s;
  logic [DATA_WIDTH-1:0]    head_data_s;
  logic [CW-1:0]            count_s;
  logic [PW-1:0]            tail_ptr_s;
  logic [SB_DEPTH-1:0]      entry_valid_s;
  logic [ADDRESS_WIDTH-1:0] entry_addr_s [SB_DEPTH];
  logic [DATA_WIDTH-1:0]    entry_data_s [SB_DEPTH];
  logic                     fwd_hit_s;
  logic [DATA_WIDTH-1:0]    fwd_data_s;
  logic [DATA_WIDTH-1:0]    wb_load_data_r;
  logic                     wb_load_valid_r;

  assign ld_s        = exValid & exMemRead;
  assign st_s        = exValid & exMemWrite;
  assign empty_s     = (count_s == CW'(0));
  assign full_s      = (count_s == CW'(SB_DEPTH));
  assign stall_s     = (flush & ~empty_s) | (st_s & full_s);
  assign accept_ld_s = ld_s & ~stall_s;
  assign accept_st_s = st_s & ~stall_s;
  assign port_busy_s = accept_ld_s | accept_st_s;
  // Draining is held off during reset so discarded entries never reach memory.
  assign drain_s     = ~port_busy_s & ~empty_s & reset;

  sb_fifo #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .SB_DEPTH      (SB_DEPTH)
  ) u_sb_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (accept_st_s),
    .push_addr   (exAddr),
    .push_data   (exStoreData),
    .pop         (drain_s),
    .head_addr   (head_addr_s),
    .head_data   (head_data_s),
    .count       (count_s),
    .tail_ptr    (tail_ptr_s),
    .entry_valid (entry_valid_s),
    .entry_addr  (entry_addr_s),
    .entry_data  (entry_data_s)
  );

  // Forwarding scan from oldest (tail-DEPTH) to youngest (tail-1); later matches override.
  always_comb begin
    logic [PW-1:0] scan_idx_v;
    logic          match_v;
    fwd_hit_s  = 1'b0;
    fwd_data_s = '0;
    scan_idx_v = '0;
    match_v    = 1'b0;
    for (int k = SB_DEPTH; k >= 1; k--) begin
      scan_idx_v = tail_ptr_s - PW'(k);
      match_v    = entry_valid_s[scan_idx_v] & (entry_addr_s[scan_idx_v] == exAddr);
      fwd_hit_s  = fwd_hit_s | match_v;
      fwd_data_s = match_v ? entry_data_s[scan_idx_v] : fwd_data_s;
    end
  end

  // MEM/WB load register: captures an accepted load, otherwise only drops valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_load_data_r  <= '0;
      wb_load_valid_r <= 1'b0;
    end else if (accept_ld_s) begin
      wb_load_data_r  <= fwd_hit_s ? fwd_data_s : dmemReadData;
      wb_load_valid_r <= 1'b1;
    end else begin
      wb_load_valid_r <= 1'b0;
    end
  end

  assign stall           = stall_s;
  assign dmemWriteEnable = drain_s;
  assign dmemAddr        = drain_s ? head_addr_s : exAddr;
  assign dmemWriteData   = head_data_s;
  assign wbLoadData      = wb_load_data_r;
  assign wbLoadValid     = wb_load_valid_r;
  assign sbCount         = count_s;
  assign sbEmpty         = empty_s;

endmodule

// File: tb/tb_mem_store_buffer.sv
// Self-checking bench for mem_store_buffer: directed scenarios plus random traffic,
// all compared against a queue-based reference model and a 16-word memory.
module tb_mem_store_buffer;
  import mem_stage_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        exValid = 1'b0, exMemRead = 1'b0, exMemWrite = 1'b0, flush = 1'b0;
  logic [31:0] exAddr = 32'd0, exStoreData = 32'd0;
  logic        stall, dmemWriteEnable, wbLoadValid, sbEmpty;
  logic [31:0] dmemAddr, dmemWriteData, dmemReadData, wbLoadData;
  logic [2:0]  sbCount;

  logic [31:0] mem     [16];
  logic [31:0] ref_mem [16];
  logic [31:0] snap    [16];
  sb_entry_t   model_q [$];

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_wb = 32'd0;
  logic        obs_stall, obs_we;
  logic [31:0] obs_addr, obs_wdata;
  int          n_stall;

  mem_store_buffer #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .SB_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .exValid(exValid), .exMemRead(exMemRead),
    .exMemWrite(exMemWrite), .exAddr(exAddr), .exStoreData(exStoreData),
    .flush(flush), .stall(stall), .dmemAddr(dmemAddr), .dmemWriteData(dmemWriteData),
    .dmemWriteEnable(dmemWriteEnable), .dmemReadData(dmemReadData),
    .wbLoadData(wbLoadData), .wbLoadValid(wbLoadValid), .sbCount(sbCount), .sbEmpty(sbEmpty)
  );

  always #5 clk = ~clk;

  assign dmemReadData = mem[dmemAddr[3:0]];

  always @(posedge clk) begin
    if (dmemWriteEnable) mem[dmemAddr[3:0]] <= dmemWriteData;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One pipeline cycle: drive, check combinational port behaviour, advance model, check registers.
  task automatic step(input logic v, input logic rd, input logic wr,
                      input logic [31:0] a, input logic [31:0] d, input logic fl);
    int          n;
    logic        e_st, e_ld, e_stall, e_drain, e_wbv;
    logic [31:0] e_res;
    sb_entry_t   e;
    @(negedge clk);
    exValid = v; exMemRead = rd; exMemWrite = wr; exAddr = a; exStoreData = d; flush = fl;
    #1;
    n       = model_q.size();
    e_st    = v & wr;
    e_ld    = v & rd;
    e_stall = (fl && n != 0) || (e_st && n == DEPTH);
    e_drain = (n != 0) && (e_stall || !(e_st || e_ld));
    obs_stall = stall; obs_we = dmemWriteEnable; obs_addr = dmemAddr; obs_wdata = dmemWriteData;
    check_eq("stall", stall, e_stall);
    check_eq("dmem_we", dmemWriteEnable, e_drain);
    if (e_drain) begin
      check_eq("drain_addr", dmemAddr, model_q[0].addr);
      check_eq("drain_data", dmemWriteData, model_q[0].data);
    end else begin
      check_eq("load_addr", dmemAddr, a);
    end
    e_wbv = 1'b0;
    e_res = last_wb;
    if (!e_stall && e_st) begin
      model_q.push_back('{addr: a, data: d});
    end else if (!e_stall && e_ld) begin
      e_wbv = 1'b1;
      e_res = ref_mem[a[3:0]];
      foreach (model_q[i]) if (model_q[i].addr == a) e_res = model_q[i].data;
    end
    if (e_drain) begin
      e = model_q.pop_front();
      ref_mem[e.addr[3:0]] = e.data;
    end
    @(posedge clk);
    #1;
    check_eq("wb_valid", wbLoadValid, e_wbv);
    check_eq("wb_data", wbLoadData, e_res);
    last_wb = e_res;
    check_eq("sb_count", sbCount, model_q.size());
    check_eq("sb_empty", sbEmpty, model_q.size() == 0);
  endtask

  task automatic idle(input logic fl);
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, fl);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    step(1'b1, 1'b0, 1'b1, a, d, 1'b0);
  endtask

  task automatic load(input logic [31:0] a);
    step(1'b1, 1'b1, 1'b0, a, 32'd0, 1'b0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b0; exValid = 1'b0; exMemRead = 1'b0; exMemWrite = 1'b0; flush = 1'b0;
    #1;
    check_eq("rst_no_we", dmemWriteEnable, 1'b0);
    @(posedge clk);
    #1;
    model_q.delete();
    last_wb = 32'd0;
    check_eq("rst_wb_valid", wbLoadValid, 1'b0);
    check_eq("rst_wb_data", wbLoadData, 32'd0);
    check_eq("rst_count", sbCount, 3'd0);
    check_eq("rst_empty", sbEmpty, 1'b1);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i]     = 32'h1000 + i;
      ref_mem[i] = 32'h1000 + i;
    end
    mem[9]     = 32'h1234;
    ref_mem[9] = 32'h1234;

    reset_dut();
    reset_dut();

    // Back-to-back stores, then idle cycles retire them in order.
    store(32'd5, 32'h11);
    check_eq("two_st_cnt1", sbCount, 3'd1);
    store(32'd6, 32'h22);
    check_eq("two_st_cnt2", sbCount, 3'd2);
    idle(1'b0);
    check_eq("drain1_we", obs_we, 1'b1);
    check_eq("drain1_addr", obs_addr, 32'd5);
    check_eq("drain1_data", obs_wdata, 32'h11);
    idle(1'b0);
    check_eq("drain2_addr", obs_addr, 32'd6);
    check_eq("drain2_data", obs_wdata, 32'h22);
    check_eq("drain_done", sbEmpty, 1'b1);

    // Youngest matching store forwards; memory untouched until drain.
    store(32'd7, 32'hAA);
    store(32'd7, 32'hBB);
    load(32'd7);
    check_eq("fwd_data", wbLoadData, 32'hBB);
    check_eq("fwd_valid", wbLoadValid, 1'b1);
    check_eq("fwd_mem_old", mem[7], 32'h1007);
    idle(1'b0);
    idle(1'b0);
    check_eq("fwd_mem_new", mem[7], 32'hBB);

    // Miss reads memory with one-cycle latency.
    load(32'd9);
    check_eq("miss_data", wbLoadData, 32'h1234);
    check_eq("miss_valid", wbLoadValid, 1'b1);
    idle(1'b0);
    check_eq("miss_valid_drop", wbLoadValid, 1'b0);

    // Full buffer plus store: one stall cycle with a drain, then accepted.
    for (int i = 0; i < 4; i++) store(32'd10 + i, 32'hA0 + i);
    check_eq("full_cnt", sbCount, 3'd4);
    store(32'd14, 32'hE0);
    check_eq("full_stall", obs_stall, 1'b1);
    check_eq("full_drain_we", obs_we, 1'b1);
    check_eq("full_drain_addr", obs_addr, 32'd10);
    store(32'd14, 32'hE0);
    check_eq("full_accept", obs_stall, 1'b0);
    check_eq("full_cnt_after", sbCount, 3'd4);
    idle(1'b0);

    // Flush with three entries: three stall cycles draining in FIFO order.
    n_stall = 0;
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      if (obs_stall) n_stall++;
      check_eq("flush_addr", obs_addr, 32'd12 + i);
    end
    check_eq("flush_stalls", n_stall, 3);
    idle(1'b1);
    check_eq("flush_release", obs_stall, 1'b0);
    check_eq("flush_empty", sbEmpty, 1'b1);

    // Reset discards queued stores without writing memory.
    store(32'd1, 32'h5151);
    store(32'd2, 32'h5252);
    store(32'd3, 32'h5353);
    for (int i = 0; i < 16; i++) snap[i] = mem[i];
    reset_dut();
    for (int i = 0; i < 3; i++) idle(1'b0);
    for (int i = 1; i < 4; i++) check_eq("rst_mem_kept", mem[i], snap[i]);

    // Random traffic over a small address window to provoke forwarding hits.
    for (int i = 0; i < 400; i++) begin
      int          r;
      logic [31:0] ra, rdat;
      logic        rfl;
      r    = $urandom_range(0, 9);
      ra   = 32'($urandom_range(0, 7));
      rdat = $urandom;
      rfl  = ($urandom_range(0, 9) == 0);
      if (r < 4)      step(1'b1, 1'b0, 1'b1, ra, rdat, rfl);
      else if (r < 7) step(1'b1, 1'b1, 1'b0, ra, 32'd0, rfl);
      else            step(1'b0, 1'b0, 1'b0, ra, rdat, rfl);
    end
    for (int i = 0; i < 8 && model_q.size() != 0; i++) idle(1'b1);
    idle(1'b0);
    for (int i = 0; i < 16; i++) check_eq("final_mem", mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
